// File: rtl/sram_like_responder_if.sv
// SRAM-like req/addr_ok/data_ok bus between a pipeline-side initiator and a memory responder.
// The initiator drives the request fields; the responder returns the two handshakes and read data.
interface sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_responder.sv
// Fixed-latency, in-order SRAM-like responder backed by a word memory.
// Writes commit and reads capture at address handshake; responses drain from a small circular queue.
module sram_like_responder #(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 addr_stall,
  sram_like_responder_if.slave bus
);

  localparam int               PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int               CNT_W    = $clog2(OUTSTANDING + 1);
  localparam int               DEPTH    = 1 << ADDR_W;
  localparam logic [2:0]       LAT      = 3'(LATENCY);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(OUTSTANDING);

  logic [31:0]            mem_q [DEPTH];

  logic [OUTSTANDING-1:0] valid_q, valid_d;
  logic [OUTSTANDING-1:0] is_read_q, is_read_d;
  logic [31:0]            data_q [OUTSTANDING];
  logic [31:0]            data_d [OUTSTANDING];
  logic [2:0]             cnt_q  [OUTSTANDING];
  logic [2:0]             cnt_d  [OUTSTANDING];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [ADDR_W-1:0]      idx;
  logic [31:0]            rd_word;
  logic                   retire_now;
  logic                   addr_ok;
  logic                   accept;
  logic                   unused_addr_bits;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign idx              = bus.addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
  assign rd_word          = mem_q[idx];

  // A full queue can still accept when the head leaves this cycle, keeping one request per cycle.
  assign retire_now = valid_q[head_q] && (cnt_q[head_q] == 3'd1);
  assign addr_ok    = resetn && !addr_stall && ((count_q < MAX_CNT) || retire_now);
  assign accept     = bus.req && addr_ok;

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = retire_now;
  assign bus.rdata   = (retire_now && is_read_q[head_q]) ? data_q[head_q] : 32'h0;

  always_comb begin
    valid_d   = valid_q;
    is_read_d = is_read_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    for (int i = 0; i < OUTSTANDING; i++) begin
      if (valid_q[i] && (cnt_q[i] > 3'd1)) begin
        cnt_d[i] = cnt_q[i] - 3'd1;
      end
    end

    if (retire_now) begin
      valid_d[head_q] = 1'b0;
      head_d          = next_ptr(head_q);
    end

    // Push after pop: when full, head and tail share a slot and the new entry must win.
    if (accept) begin
      valid_d[tail_q]   = 1'b1;
      is_read_d[tail_q] = !bus.wr;
      data_d[tail_q]    = bus.wr ? 32'h0 : rd_word;
      cnt_d[tail_q]     = LAT;
      tail_d            = next_ptr(tail_q);
    end

    case ({accept, retire_now})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= '0;
      is_read_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        data_q[i] <= 32'h0;
        cnt_q[i]  <= 3'd0;
      end
    end else begin
      valid_q   <= valid_d;
      is_read_q <= is_read_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Memory contents survive reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Responder (slave) end of the SRAM-like req/addr_ok/data_ok interface that the pipeline fetch and memory stages drive as initiators.
- Accepts read/write requests, backs them with an internal word memory and returns responses strictly in order after a fixed latency, with bounded outstanding requests.
- Used as the instruction/data memory model in stage-level benches, and as the standalone target for handshake and cancel/flush verification before the AXI bridge exists.

Parameters:
- ADDR_W, 10, word-index width; memory holds 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from address handshake to data_ok; legal range 1..7.
- OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  1  initiator request valid.
- wr  in  1  1 = write, 0 = read; sampled with req.
- wstrb  in  4  byte enables for writes; ignored for reads.
- addr  in  32  byte address; word index = addr[ADDR_W+1:2]; other bits ignored.
- wdata  in  32  write data.
- addr_stall  in  1  test hook; forces addr_ok low while 1.
- addr_ok  out  1  address handshake; the request is accepted in a cycle with req && addr_ok.
- data_ok  out  1  one-cycle response pulse, in request order.
- rdata  out  32  read data, valid only while data_ok=1 for a read; 0 otherwise.

Behaviour:
- Reset (resetn=0, asynchronous): queue is emptied, all pending responses are dropped, and the latency counters are cleared. addr_ok=0, data_ok=0, rdata=0. Memory contents are not reset.
- Queue entry fields:
  - entry valid bit
  - is_read
  - captured data (32 bits)
  - countdown (3 bits)
- Queue organisation: circular buffer of OUTSTANDING entries with head/tail pointers and a count. Pointers wrap modulo OUTSTANDING.
- addr_ok = resetn && !addr_stall && (count < OUTSTANDING || retire_now). retire_now = the head entry is valid with countdown==1 this cycle. addr_ok must not depend on req.
- Accept (req && addr_ok at a posedge), per request type:
  - Write: mem[idx] byte lanes with wstrb[i]=1 are updated at that edge.
  - Read: mem[idx] is read at acceptance; the captured value is unaffected by any later write.
  - In both cases an entry is pushed at the tail with countdown=LATENCY.
- Countdown: every cycle, each valid entry with countdown>1 decrements by 1.
- Response: data_ok=1 in exactly the cycle when the head entry has countdown==1. A request accepted at edge T therefore produces data_ok in the cycle ending at edge T+LATENCY. rdata = head data if the entry is a read, else 0. The head is popped at the end of that cycle.
- Ordering: at most one accept per cycle, so at most one entry reaches countdown 1 per cycle. Responses are strictly FIFO and never reordered or merged.
- Simultaneous push and pop in the same cycle: count is unchanged, and both pointers advance.
- Full (count==OUTSTANDING and no retire): addr_ok=0. A req held high waits with no side effects.
- Back-to-back requests: with LATENCY <= OUTSTANDING, one request per cycle is sustained indefinitely. Otherwise throughput is OUTSTANDING per LATENCY cycles.
- Same-word write followed by read, accepted in consecutive cycles: the read returns the post-write value. Write-before-read order holds because writes commit at accept.
- Initiator cancel (discarding a data_ok it no longer wants) is invisible to this block: every accepted request is answered exactly once.
- Reset asserted mid-operation: outstanding responses are never issued. After release, the first accept behaves as from an empty queue.
- Illegal combinations:
  - req with X on wr is undefined.
  - wstrb=0 on a write completes as a no-op write, and data_ok is still returned.

Test Plan:
- Write 0xDEADBEEF to 0x1C000010 with wstrb=4'hF at edge T, then read the same address at T+1 (LATENCY=2) -> data_ok at T+2 (write, rdata=0) and at T+3 (rdata=0xDEADBEEF).
- Partial write of 0x000000AA with wstrb=4'b0001 over 0x11223344, then read -> rdata=0x112233AA.
- Reads held on req every cycle to 0x0, 0x4, 0x8, 0xC, with OUTSTANDING=2 and LATENCY=3 -> addr_ok pattern 1,1,0,1,1,0…, data_ok pulses in the same order, count never exceeds 2.
- addr_stall=1 for 5 cycles with req=1 -> no accept and no data_ok. Request accepted the cycle after addr_stall falls, response LATENCY cycles later.
- Two reads accepted, then resetn pulsed low between them -> no data_ok ever appears, addr_ok=0 during reset, the next read after release responds after exactly LATENCY cycles.
- LATENCY=1, reads issued every cycle to incrementing addresses -> one data_ok per cycle with rdata matching preloaded mem[i], no bubbles.
